// File: rtl/feedback_channel_arbiter.sv
// rtl/feedback_channel_arbiter.sv - round-robin arbiter sharing one actuator word among feedback channels
// Optional GRANT_STATS_EN adds per-channel grant counters and sticky timeout flags.
module feedback_channel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 16,
    parameter int CYC_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*OUT_W-1:0] req_value,
    input  logic [CYC_W-1:0]        max_grant_cyc,
    input  logic [CYC_W-1:0]        guard_cyc,
    input  logic [OUT_W-1:0]        idle_value,
`ifdef GRANT_STATS_EN
    input  logic                    stats_clear,
    output logic [NUM_CH*16-1:0]    grant_count,
    output logic [NUM_CH-1:0]       timeout_flag,
`endif
    output logic [NUM_CH-1:0]       grant,
    output logic [OUT_W-1:0]        out,
    output logic                    busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;

    state_t             state, state_d;
    logic [NUM_CH-1:0]  grant_d;
    logic [OUT_W-1:0]   out_d;
    logic [CYC_W-1:0]   counter, counter_d;
    logic [IDX_W-1:0]   cur, cur_d;
    logic [IDX_W-1:0]   rr_ptr, rr_d;
    logic               unlim, unlim_d;
    logic               arb, start, timeout_ev;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick, pick_next;
    int                 idx;

    // Scan downward so the lowest offset from rr_ptr is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick       = IDX_W'(idx);
            end
        end
        pick_next = (pick == IDX_W'(NUM_CH - 1)) ? '0 : pick + IDX_W'(1);
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        out_d      = out;
        counter_d  = counter;
        cur_d      = cur;
        unlim_d    = unlim;
        rr_d       = rr_ptr;
        arb        = 1'b0;
        start      = 1'b0;
        timeout_ev = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            grant_d = '0;
            out_d   = idle_value;
        end else begin
            case (state)
                S_IDLE: arb = 1'b1;
                S_GRANT: begin
                    timeout_ev = !unlim && (counter == '0);
                    if (!req[cur] || timeout_ev) begin
                        if (guard_cyc != '0) begin
                            state_d   = S_GUARD;
                            counter_d = guard_cyc - CYC_W'(1);
                            grant_d   = '0;
                            out_d     = idle_value;
                        end else begin
                            arb = 1'b1;
                        end
                    end else begin
                        out_d = req_value[cur*OUT_W +: OUT_W];
                        if (!unlim) counter_d = counter - CYC_W'(1);
                    end
                end
                S_GUARD: begin
                    if (counter == '0) begin
                        arb = 1'b1;
                    end else begin
                        counter_d = counter - CYC_W'(1);
                        grant_d   = '0;
                        out_d     = idle_value;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Shared by IDLE, guard expiry and zero-guard back-to-back grants.
            if (arb) begin
                if (pick_valid) begin
                    start     = 1'b1;
                    state_d   = S_GRANT;
                    grant_d   = NUM_CH'(1) << pick;
                    out_d     = req_value[pick*OUT_W +: OUT_W];
                    counter_d = max_grant_cyc - CYC_W'(1);
                    unlim_d   = (max_grant_cyc == '0);
                    cur_d     = pick;
                    rr_d      = pick_next;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    out_d   = idle_value;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            grant   <= '0;
            out     <= '0;
            counter <= '0;
            cur     <= '0;
            rr_ptr  <= '0;
            unlim   <= 1'b0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            out     <= out_d;
            counter <= counter_d;
            cur     <= cur_d;
            rr_ptr  <= rr_d;
            unlim   <= unlim_d;
        end
    end

    assign busy = (state != S_IDLE);

`ifdef GRANT_STATS_EN
    logic [15:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_CH; g++) begin
            if (!reset || stats_clear) begin
                cnt[g]          <= '0;
                timeout_flag[g] <= 1'b0;
            end else begin
                if (start && pick == IDX_W'(g) && cnt[g] != 16'hFFFF) cnt[g] <= cnt[g] + 16'd1;
                if (timeout_ev && cur == IDX_W'(g)) timeout_flag[g] <= 1'b1;
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int g = 0; g < NUM_CH; g++) grant_count[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_feedback_channel_arbiter.sv
// tb/tb_feedback_channel_arbiter.sv - randomized and directed bench against a cycle-level reference model
module tb_feedback_channel_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  req;
    logic [N*W-1:0] req_value;
    logic [31:0]   max_grant_cyc;
    logic [31:0]   guard_cyc;
    logic [W-1:0]  idle_value;
    logic [N-1:0]  grant;
    logic [W-1:0]  out;
    logic          busy;
`ifdef GRANT_STATS_EN
    logic          stats_clear;
    logic [N*16-1:0] grant_count;
    logic [N-1:0]  timeout_flag;
`endif

    int checks = 0;
    int errors = 0;

    int          m_mode;
    int          m_ch;
    int          m_rr;
    longint      m_used;
    longint      m_limit;
    longint      m_guard_left;
    logic [N-1:0] e_grant;
    logic [W-1:0] e_out;

    feedback_channel_arbiter #(.NUM_CH(N), .OUT_W(W), .CYC_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .req_value(req_value),
        .max_grant_cyc(max_grant_cyc), .guard_cyc(guard_cyc), .idle_value(idle_value),
`ifdef GRANT_STATS_EN
        .stats_clear(stats_clear), .grant_count(grant_count), .timeout_flag(timeout_flag),
`endif
        .grant(grant), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 granted, 2 guarding; grant length counted up from zero.
    task automatic model_step();
        bit arb;
        int c;
        if (!reset) begin
            m_mode = 0; m_rr = 0; m_ch = 0; m_used = 0;
            e_grant = '0; e_out = '0;
        end else if (!enable) begin
            m_mode = 0; e_grant = '0; e_out = idle_value;
        end else begin
            arb = 0;
            if (m_mode == 0) begin
                arb = 1;
            end else if (m_mode == 1) begin
                m_used++;
                if (!req[m_ch] || (m_limit != 0 && m_used >= m_limit)) begin
                    if (guard_cyc != 0) begin
                        m_mode = 2; m_guard_left = guard_cyc;
                        e_grant = '0; e_out = idle_value;
                    end else begin
                        arb = 1;
                    end
                end else begin
                    e_out = req_value[m_ch*W +: W];
                end
            end else begin
                m_guard_left--;
                if (m_guard_left == 0) arb = 1;
                else e_out = idle_value;
            end
            if (arb) begin
                c = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (req[(m_rr + i) % N]) c = (m_rr + i) % N;
                if (c >= 0) begin
                    m_mode = 1; m_ch = c; m_used = 0; m_limit = max_grant_cyc;
                    e_grant = N'(1) << c; e_out = req_value[c*W +: W];
                    m_rr = (c + 1) % N;
                end else begin
                    m_mode = 0; e_grant = '0; e_out = idle_value;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_grant", 32'(grant), 32'(e_grant));
        check("model_out", 32'(out), 32'(e_out));
        check("model_busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; req = '0; max_grant_cyc = 0; guard_cyc = 0;
        idle_value = 16'h0100;
        for (int c = 0; c < N; c++) req_value[c*W +: W] = 16'(16'hA000 + c);
`ifdef GRANT_STATS_EN
        stats_clear = 1'b0;
`endif
        // reset held, then release into idle
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_out", 32'(out), 32'h0);
        end
        reset = 1'b1;
        cycle();
        check("idle_out", 32'(out), 32'h0100);

        // single requester, unlimited grant
        req_value[1*W +: W] = 16'h1234;
        req = 4'b0010;
        cycle();
        check("t2_grant", 32'(grant), 32'h2);
        check("t2_out", 32'(out), 32'h1234);
        req = 4'b0000;
        cycle();
        check("t2_drop_grant", 32'(grant), 32'h0);
        check("t2_drop_out", 32'(out), 32'h0100);

        // all requesting with timeout and guard
        do_reset();
        req = 4'b1111; max_grant_cyc = 5; guard_cyc = 2;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 5; j++) begin
                cycle();
                check("t3_grant", 32'(grant), 32'(N'(1) << (k % N)));
                check("t3_busy", 32'(busy), 32'h1);
            end
            if (k < 4) begin
                for (int j = 0; j < 2; j++) begin
                    cycle();
                    check("t3_guard", 32'(grant), 32'h0);
                    check("t3_gbusy", 32'(busy), 32'h1);
                end
            end
        end

        // sole requester re-granted back-to-back
        do_reset();
        req = 4'b0100; max_grant_cyc = 3; guard_cyc = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("t4_grant", 32'(grant), 32'h4);
        end

        // enable drop keeps the round-robin pointer
        do_reset();
        req = 4'b0010; max_grant_cyc = 0; guard_cyc = 0;
        cycle();
        check("t5_grant", 32'(grant), 32'h2);
        cycle();
        enable = 1'b0;
        cycle();
        check("t5_off_grant", 32'(grant), 32'h0);
        check("t5_off_out", 32'(out), 32'(idle_value));
        enable = 1'b1; req = 4'b1111;
        cycle();
        check("t5_resume", 32'(grant), 32'h4);

`ifdef GRANT_STATS_EN
        do_reset();
        req = 4'b1111; max_grant_cyc = 5; guard_cyc = 2;
        for (int k = 0; k < 55; k++) cycle();
        for (int c = 0; c < N; c++) check("t6_count", 32'(grant_count[c*16 +: 16]), 32'd2);
        check("t6_tflag", 32'(timeout_flag), 32'hF);
        stats_clear = 1'b1;
        cycle();
        stats_clear = 1'b0;
        check("t6_clr_count", 32'(grant_count), 32'h0);
        check("t6_clr_tflag", 32'(timeout_flag), 32'h0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int c = 0; c < N; c++) req_value[c*W +: W] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) max_grant_cyc = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) guard_cyc = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) idle_value = 16'($urandom);
            enable = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
